// File: rtl/rgb2nes_quant.sv
// rgb2nes_quant
//   Nearest-colour search from a 24-bit RRGGBB pixel to a 6-bit NES palette
//   index. The 64-entry palette ROM is scanned one entry per clock. The
//   L1 distance |dR|+|dG|+|dB| is computed for each entry, and the lowest
//   distance among the selectable entries is kept. When distances are
//   equal, the lower index wins.
//
// Ports
//   i_clk    system clock
//   i_rst    synchronous reset, active-high
//   i_valid  input colour valid (accepted when o_ready=1)
//   o_ready  block idle and able to accept a colour
//   i_rgb    colour to quantise, [23:16]=R [15:8]=G [7:0]=B
//   o_valid  result valid, held until i_ready
//   i_ready  downstream accepts the result
//   o_index  best palette index
//   o_dist   distance of the best match
//
// Parameter
//   EARLY_EXIT  1: stop at the first selectable entry whose distance is 0
//               0: always scan all 64 entries
module rgb2nes_quant #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [23:0] i_rgb,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [5:0]  o_index,
  output logic [9:0]  o_dist
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q,     state_d;
  logic [5:0]  scan_idx_q,  scan_idx_d;
  logic [23:0] rgb_q,       rgb_d;
  logic [9:0]  best_dist_q, best_dist_d;
  logic [5:0]  best_idx_q,  best_idx_d;

  logic [23:0] pal_rgb;
  logic [9:0]  cur_dist;
  logic        cur_cand;

  // Palette ROM. Entries that can never be selected read as black. Because
  // they are excluded from selection, they cannot shadow index 0x0F.
  function automatic logic [23:0] pal_lookup(input logic [5:0] idx);
    logic [23:0] v;
    case (idx)
      6'h00: v = 24'h757575;
      6'h01: v = 24'h271B8F;
      6'h02: v = 24'h0000AB;
      6'h03: v = 24'h47009F;
      6'h04: v = 24'h8F0077;
      6'h05: v = 24'hAB0013;
      6'h06: v = 24'hA70000;
      6'h07: v = 24'h7F0B00;
      6'h08: v = 24'h432F00;
      6'h09: v = 24'h004700;
      6'h0A: v = 24'h005100;
      6'h0B: v = 24'h003F17;
      6'h0C: v = 24'h1B3F5F;
      6'h0F: v = 24'h000000;
      6'h10: v = 24'hBCBCBC;
      6'h11: v = 24'h0073EF;
      6'h12: v = 24'h233BEF;
      6'h13: v = 24'h8300F3;
      6'h14: v = 24'hBF00BF;
      6'h15: v = 24'hE7005B;
      6'h16: v = 24'hDB2B00;
      6'h17: v = 24'hCB4F0F;
      6'h18: v = 24'h8B7300;
      6'h19: v = 24'h009700;
      6'h1A: v = 24'h00AB00;
      6'h1B: v = 24'h00933B;
      6'h1C: v = 24'h00838B;
      6'h20: v = 24'hFFFFFF;
      6'h21: v = 24'h3FBFFF;
      6'h22: v = 24'h5F97FF;
      6'h23: v = 24'hA78BFD;
      6'h24: v = 24'hF77BFF;
      6'h25: v = 24'hFF77B7;
      6'h26: v = 24'hFF7763;
      6'h27: v = 24'hFF9B3B;
      6'h28: v = 24'hF3BF3F;
      6'h29: v = 24'h83D313;
      6'h2A: v = 24'h4FDF4B;
      6'h2B: v = 24'h58F898;
      6'h2C: v = 24'h00EBDB;
      6'h30: v = 24'hFFFFFF;
      6'h31: v = 24'hABE7FF;
      6'h32: v = 24'hC7D7FF;
      6'h33: v = 24'hD7CBFF;
      6'h34: v = 24'hFFC7FF;
      6'h35: v = 24'hFFC7DB;
      6'h36: v = 24'hFFBFB3;
      6'h37: v = 24'hFFDBAB;
      6'h38: v = 24'hFFE7A3;
      6'h39: v = 24'hE3FFA3;
      6'h3A: v = 24'hABF3BF;
      6'h3B: v = 24'hB3FFCF;
      6'h3C: v = 24'h9FFFF3;
      default: v = 24'h000000;
    endcase
    return v;
  endfunction

  // Absolute difference of two unsigned channels, via a signed 9-bit delta.
  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] d;
    logic signed [8:0] nd;
    d  = $signed({1'b0, a}) - $signed({1'b0, b});
    nd = -d;
    return d[8] ? nd[7:0] : d[7:0];
  endfunction

  // Sum of three channel deltas. The maximum is 765, so 10 bits never overflow.
  function automatic logic [9:0] l1_dist(input logic [23:0] x, input logic [23:0] y);
    return {2'b00, abs_diff(x[23:16], y[23:16])}
         + {2'b00, abs_diff(x[15:8],  y[15:8])}
         + {2'b00, abs_diff(x[7:0],   y[7:0])};
  endfunction

  // Selectable entries: low nibble 0..C in every row, plus 0x0F only.
  function automatic logic is_candidate(input logic [5:0] idx);
    return (idx[3:0] <= 4'hC) || (idx == 6'h0F);
  endfunction

  // Compare stage: ROM read and distance for the entry being scanned.
  always_comb begin
    pal_rgb  = pal_lookup(scan_idx_q);
    cur_dist = l1_dist(rgb_q, pal_rgb);
    cur_cand = is_candidate(scan_idx_q);
  end

  // Next-state and best-so-far update.
  always_comb begin
    state_d     = state_q;
    scan_idx_d  = scan_idx_q;
    rgb_d       = rgb_q;
    best_dist_d = best_dist_q;
    best_idx_d  = best_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          rgb_d       = i_rgb;
          best_dist_d = 10'h3FF;
          best_idx_d  = 6'h00;
          scan_idx_d  = 6'h00;
          state_d     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // A strict less-than keeps the earlier (lower) index when distances tie.
        if (cur_cand && (cur_dist < best_dist_q)) begin
          best_dist_d = cur_dist;
          best_idx_d  = scan_idx_q;
        end
        scan_idx_d = scan_idx_q + 6'd1;
        if ((scan_idx_q == 6'h3F) ||
            (EARLY_EXIT && cur_cand && (cur_dist == 10'd0))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers. Reset takes priority over a simultaneous handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      scan_idx_q  <= 6'h00;
      best_dist_q <= 10'h3FF;
      best_idx_q  <= 6'h00;
    end else begin
      state_q     <= state_d;
      scan_idx_q  <= scan_idx_d;
      best_dist_q <= best_dist_d;
      best_idx_q  <= best_idx_d;
    end
  end

  // The latched colour is data only. It is reloaded on every accept.
  always_ff @(posedge i_clk) begin
    rgb_q <= rgb_d;
  end

  // Output stage.
  always_comb begin
    o_ready = (state_q == ST_IDLE);
    o_valid = (state_q == ST_DONE);
    o_index = best_idx_q;
    o_dist  = best_dist_q;
  end

endmodule

// File: doc/rgb2nes_quant.md
Name: rgb2nes_quant

Overview:
- Converts a 24-bit RRGGBB colour into the nearest 6-bit NES palette index. This is the inverse of the PPU palette-to-RGB path.
- Used by the frame-capture / image-import path to turn host-supplied RGB pixels into PPU palette indices.
- The search is a sequential scan of an internal 64-entry palette ROM, one entry per clock, with valid/ready handshakes on both sides.

Parameters:
- EARLY_EXIT, 1: when 1, the scan stops as soon as an entry with distance 0 is found; when 0, all 64 entries are always scanned.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_valid  in  1  input colour valid
- o_ready  out  1  block idle and able to accept a colour
- i_rgb  in  24  colour to quantise, [23:16]=R, [15:8]=G, [7:0]=B
- o_valid  out  1  result valid; held until accepted
- i_ready  in  1  downstream accepts the result
- o_index  out  6  best palette index
- o_dist  out  10  distance of the best match

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_rst.
- Reset values: o_ready=1, o_valid=0, o_index=6'h00, o_dist=10'h3FF. Internal index counter=0, FSM=IDLE.
- Palette ROM, 24-bit RRGGBB per entry:
  - 0x00-0x0C: 757575 271B8F 0000AB 47009F 8F0077 AB0013 A70000 7F0B00 432F00 004700 005100 003F17 1B3F5F
  - 0x10-0x1C: BCBCBC 0073EF 233BEF 8300F3 BF00BF E7005B DB2B00 CB4F0F 8B7300 009700 00AB00 00933B 00838B
  - 0x20-0x2C: FFFFFF 3FBFFF 5F97FF A78BFD F77BFF FF77B7 FF7763 FF9B3B F3BF3F 83D313 4FDF4B 58F898 00EBDB
  - 0x30-0x3C: FFFFFF ABE7FF C7D7FF D7CBFF FFC7FF FFC7DB FFBFB3 FFDBAB FFE7A3 E3FFA3 ABF3BF B3FFCF 9FFFF3
  - 0x0F: 000000
- Candidate set: index low nibble 0x0-0xC, plus 0x0F. All other indices (0x0D, 0x0E, 0x1D-0x1F, 0x2D-0x2F, 0x3D-0x3F) are scanned but never selected.
- Distance: |dR|+|dG|+|dB|, unsigned, 10 bits, maximum 765. No saturation is needed.
- Selection: an entry replaces the current best only if its distance is strictly less. Ties therefore go to the lower index, e.g. FFFFFF gives 0x20, never 0x30.
- FSM:
  - IDLE: o_ready=1. On i_valid&o_ready (cycle T): latch i_rgb, set best_dist=0x3FF and best_idx=0, go to SCAN. o_ready drops at T+1.
  - SCAN: cycle T+1+k evaluates index k, for k=0..63.
    - Leave after k=63.
    - If EARLY_EXIT=1, also leave on the first candidate with distance 0.
    - Go to DONE.
  - DONE: o_valid=1, with o_index/o_dist stable. On o_valid&i_ready, return to IDLE next cycle (o_valid=0, o_ready=1).
- Latency:
  - o_valid rises at T+65 for a full scan.
  - With an early exit at index k, o_valid rises at T+k+2.
  - Minimum accept-to-accept interval is 66 cycles with zero backpressure.
- Input changes during SCAN/DONE are ignored; the latched colour is used.
- i_valid while o_ready=0 is ignored; the source must hold it.
- Backpressure: DONE holds indefinitely with outputs frozen.
- i_rst mid-SCAN or in DONE: the next cycle shows reset values, and the in-flight result is discarded (never presented).
- i_rst takes priority over a simultaneous handshake.

Test Plan:
- Reset, then drive 757575 with i_ready=1 and EARLY_EXIT=0 -> o_index=0x00, o_dist=0, o_valid at exactly T+65, one-cycle pulse, o_ready back at T+66.
- Drive 000000 with EARLY_EXIT=1 -> o_index=0x0F (never 0x0D/0x0E), o_dist=0, o_valid at T+17. Drive FFFFFF -> o_index=0x20, o_dist=0, o_valid at T+34.
- Drive 767574 -> o_index=0x00, o_dist=2. Drive 0000AC -> o_index=0x02, o_dist=1, full 64-entry scan.
- Backpressure: hold i_ready=0 for 10 cycles after o_valid -> o_valid, o_index and o_dist stable, o_ready=0, new i_valid ignored. Release -> next input is accepted only after the handshake.
- Reset asserted at T+20 mid-scan -> next cycle o_ready=1, o_valid=0, o_index=0, o_dist=0x3FF. No stale result appears. A fresh 00AB00 gives 0x1A, dist 0.
- Random sweep of 1000 colours against a software nearest-match model (same L1 distance, same candidate set, lowest-index tie-break) -> exact match on o_index and o_dist.
